// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: ALU selects, CC reset
// value and the response-holding FSM encoding.
package alu_arbiter_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // {ZF, SF, OF} after reset
  localparam logic [2:0] CC_RST = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational Y86 ALU: add/sub/and/xor with a signed-overflow flag that is
// only meaningful for add and sub.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             of
);

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign sa   = a;
  assign sb   = b;
  assign sum  = sa + sb;
  assign diff = sa - sb;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        of     = add_ovf(sa, sb, sum);
      end
      ALU_SUB: begin
        result = diff;
        of     = sub_ovf(sa, sb, diff);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; registers the
// result into a single id-tagged response channel and owns the Y86 CC register.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_set_cc,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_set_cc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  state_t           state;
  logic             last_grant;
  logic             can_accept;
  logic             gnt_p0;
  logic             xfer_p0;
  logic [1:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             set_cc_p0;
  logic [WIDTH-1:0] result_p0;
  logic             of_p0;

  // Stage p0: grant and operand mux (combinational, same cycle as accept).
  // rst_n gates acceptance so nothing is handshaken while reset is held.
  always_comb begin
    can_accept = rst_n & ((state == IDLE) | rsp_ready);
    case (req_valid)
      2'b10:   gnt_p0 = 1'b1;
      2'b11:   gnt_p0 = ~last_grant;
      default: gnt_p0 = 1'b0;
    endcase
    req_ready = 2'b00;
    if (can_accept) req_ready[gnt_p0] = req_valid[gnt_p0];
    xfer_p0   = |req_ready;
    op_p0     = gnt_p0 ? req1_op     : req0_op;
    a_p0      = gnt_p0 ? req1_a      : req0_a;
    b_p0      = gnt_p0 ? req1_b      : req0_b;
    set_cc_p0 = gnt_p0 ? req1_set_cc : req0_set_cc;
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .result (result_p0),
    .of     (of_p0)
  );

  // Stage p1: registered response, FSM and condition codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      rsp_valid             <= 1'b0;
      rsp_data              <= '0;
      rsp_id                <= 1'b0;
      rsp_of                <= 1'b0;
      last_grant            <= 1'b1;
      {cc_zf, cc_sf, cc_of} <= CC_RST;
    end else if (xfer_p0) begin
      state      <= RESP;
      rsp_valid  <= 1'b1;
      rsp_data   <= result_p0;
      rsp_of     <= of_p0;
      rsp_id     <= gnt_p0;
      last_grant <= gnt_p0;
      if (set_cc_p0) begin
        cc_zf <= (result_p0 == '0);
        cc_sf <= result_p0[WIDTH-1];
        cc_of <= of_p0;
      end
    end else if ((state == RESP) && rsp_ready) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: vector table, directed multi-cycle sequences and
// a randomized phase checked every cycle against a transaction-level model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_op;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req0_set_cc;
  logic [1:0]  req1_op;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        req1_set_cc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_id;
  logic        rsp_of;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  int n_pass  = 0;
  int n_total = 0;
  logic mon_en = 1'b0;

  alu_arbiter #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_set_cc(req0_set_cc),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_set_cc(req1_set_cc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_of     (rsp_of),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic        m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  logic        m_id    = 1'b0;
  logic        m_of    = 1'b0;
  logic        m_last  = 1'b1;
  logic [2:0]  m_cc    = 3'b100;

  function automatic void model_alu(input logic [1:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic of);
    longint sa, sb;
    logic signed [127:0] wa, wb, w, wmax, wmin;
    sa = a; sb = b;
    wa = sa; wb = sb;
    wmax = 128'sh7FFF_FFFF_FFFF_FFFF;
    wmin = -wmax - 128'sd1;
    r = '0; of = 1'b0; w = '0;
    case (op)
      2'd0: begin w = wa + wb; r = a + b; of = (w > wmax) || (w < wmin); end
      2'd1: begin w = wa - wb; r = a - b; of = (w > wmax) || (w < wmin); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
  endfunction

  function automatic logic [1:0] model_ready();
    logic [1:0] r;
    int winner;
    r = 2'b00;
    if (rst_n === 1'b1 && (!m_valid || rsp_ready)) begin
      if (req_valid == 2'b11) winner = m_last ? 0 : 1;
      else if (req_valid == 2'b10) winner = 1;
      else winner = 0;
      if (req_valid != 2'b00) r[winner] = 1'b1;
    end
    return r;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_of = 1'b0;
    m_last = 1'b1; m_cc = 3'b100;
  end

  always @(posedge clk) begin
    logic [1:0]  r;
    logic [63:0] res;
    logic        of;
    if (rst_n === 1'b1) begin
      r = model_ready();
      if (r != 2'b00) begin
        if (r[1]) model_alu(req1_op, req1_a, req1_b, res, of);
        else      model_alu(req0_op, req0_a, req0_b, res, of);
        m_valid = 1'b1; m_data = res; m_of = of; m_id = r[1]; m_last = r[1];
        if (r[1] ? req1_set_cc : req0_set_cc) m_cc = {res == 64'd0, res[63], of};
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_req_ready", req_ready, model_ready());
      check("mon_rsp_valid", rsp_valid, m_valid);
      check("mon_rsp_data", rsp_data, m_data);
      check("mon_rsp_id", rsp_id, m_id);
      check("mon_rsp_of", rsp_of, m_of);
      check("mon_cc", {cc_zf, cc_sf, cc_of}, m_cc);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rand_operand();
    case ($urandom % 6)
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic cc);
    if (i == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_set_cc = cc;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_set_cc = cc;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] data;
    logic        of;
    logic        zf;
    logic        sf;
  } vec_t;

  vec_t tbl[8];
  logic [1:0] rdy_seen;

  initial begin
    tbl[0] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{2'd1, 64'd5, 64'd5, 64'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2'd2, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'd3, 64'hFF, 64'hFF, 64'h0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'd1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{2'd1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    set_req(0, 2'd0, 64'd0, 64'd0, 1'b0);
    set_req(1, 2'd0, 64'd0, 64'd0, 1'b0);
    #2 rst_n = 1'b0;
    mon_en = 1'b1;

    // Reset with random inputs
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'($urandom); rsp_ready = 1'($urandom);
      set_req(0, 2'($urandom), rand_operand(), rand_operand(), 1'b1);
      set_req(1, 2'($urandom), rand_operand(), rand_operand(), 1'b1);
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
      tick();
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // Vector table through requester 0
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(0, tbl[k].op, tbl[k].a, tbl[k].b, 1'b1);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("tbl_valid", rsp_valid, 1'b1);
      check("tbl_id", rsp_id, 1'b0);
      check("tbl_data", rsp_data, tbl[k].data);
      check("tbl_of", rsp_of, tbl[k].of);
      check("tbl_cc", {cc_zf, cc_sf, cc_of}, {tbl[k].zf, tbl[k].sf, tbl[k].of});
      tick();
    end

    // Contention with rsp_ready held high
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 2'd1, 64'd5, 64'd5, 1'b1);
    set_req(1, 2'd2, 64'hF0, 64'h3C, 1'b0);
    req_valid = 2'b11;
    @(negedge clk);
    check("cont_first_ready", req_ready, 2'b01);
    tick();
    @(negedge clk);
    check("cont1_id", rsp_id, 1'b0);
    check("cont1_data", rsp_data, 64'h0);
    check("cont1_zf", cc_zf, 1'b1);
    check("cont1_ready", req_ready, 2'b10);
    tick();
    @(negedge clk);
    check("cont2_id", rsp_id, 1'b1);
    check("cont2_data", rsp_data, 64'h30);
    check("cont2_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    tick();
    @(negedge clk);
    check("cont3_id", rsp_id, 1'b0);
    check("cont3_valid", rsp_valid, 1'b1);
    tick();
    req_valid = 2'b00;
    tick();

    // Backpressure: response held while rsp_ready is low
    set_req(0, 2'd0, 64'd2, 64'd3, 1'b0);
    req_valid = 2'b01;
    tick();
    set_req(1, 2'd1, 64'd9, 64'd2, 1'b0);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", req_ready, 2'b00);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_data", rsp_data, 64'd5);
      check("bp_id", rsp_id, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("bp_after_id", rsp_id, 1'b1);
    check("bp_after_data", rsp_data, 64'd7);
    tick();

    // Logic op clears OF/SF after an overflowing add
    set_req(0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    req_valid = 2'b01;
    tick();
    set_req(1, 2'd3, 64'hFF, 64'hFF, 1'b1);
    req_valid = 2'b10;
    @(negedge clk);
    check("xor_pre_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("xor_data", rsp_data, 64'h0);
    check("xor_id", rsp_id, 1'b1);
    check("xor_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    tick();

    // Reset asserted while a response is held
    set_req(0, 2'd0, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    check("midrst_pre_valid", rsp_valid, 1'b1);
    check("midrst_pre_sf", cc_sf, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_data", rsp_data, 64'h0);
    check("midrst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic with protocol-compliant holding
    rdy_seen = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !rdy_seen[i])) begin
          req_valid[i] = ($urandom % 10) < 6;
          set_req(i, 2'($urandom), rand_operand(), rand_operand(), 1'($urandom));
        end
      end
      rsp_ready = ($urandom % 10) < 7;
      @(negedge clk);
      rdy_seen = req_ready;
      tick();
    end
    req_valid = 2'b00;
    tick();
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
